// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared widths, segment-count helper and FILL/PEND state enum for serializer/deserializer
package serdes_pkg;

    localparam int unsigned DEF_NARROW_W = 32;
    localparam int unsigned DEF_WIDE_W   = 512;

    function automatic int unsigned seg_count(input int unsigned narrow_w, input int unsigned wide_w);
        return wide_w / narrow_w;
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } serdes_state_t;

endpackage

// File: rtl/deserializer_out_buf.sv
// rtl/deserializer_out_buf.sv - output word register with data_ready/read_data handshake
module deserializer_out_buf #(
    parameter int unsigned width = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_data,
    input  logic             read_data,
    output logic             data_ready,
    output logic [width-1:0] data_out,
    output logic             accept
);

    // Free now, or freed by a consume on this very edge (back-to-back words without a bubble).
    assign accept = !data_ready || read_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_ready <= 1'b0;
            data_out   <= '0;
        end else if (load) begin
            data_ready <= 1'b1;
            data_out   <= load_data;
        end else if (read_data) begin
            data_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - narrow-beat to wide-word deserializer, LSB-first; optional overflow port via DESERIALIZER_OVERFLOW_EN
module deserializer
    import serdes_pkg::*;
#(
    parameter int unsigned in_bit_width  = DEF_NARROW_W,
    parameter int unsigned out_bit_width = DEF_WIDE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_data,
    input  logic [in_bit_width-1:0]  data_in,
    output logic                     data_ready,
    input  logic                     read_data,
    output logic [out_bit_width-1:0] data_out
`ifdef DESERIALIZER_OVERFLOW_EN
    ,
    output logic                     overflow
`endif
);

    localparam int unsigned N     = seg_count(in_bit_width, out_bit_width);
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(N - 1);

    generate
        if ((out_bit_width % in_bit_width) != 0 || N < 2) begin : g_bad_ratio
            $error("deserializer: out_bit_width must be an integer multiple (>=2) of in_bit_width");
        end
    endgenerate

    serdes_state_t            state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [out_bit_width-1:0] asm_q, asm_d;
    logic [out_bit_width-1:0] merged;
    logic [out_bit_width-1:0] load_word;
    logic                     load;
    logic                     accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        load      = 1'b0;
        load_word = asm_q;
        merged    = asm_q;
        merged[32'(cnt_q) * in_bit_width +: in_bit_width] = data_in;
        case (state_q)
            FILL: begin
                if (write_data) begin
                    if (cnt_q == LAST_SEG) begin
                        cnt_d = '0;
                        if (accept) begin
                            load      = 1'b1;
                            load_word = merged;
                        end else begin
                            asm_d   = merged;
                            state_d = PEND;
                        end
                    end else begin
                        asm_d = merged;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PEND: begin
                // Incoming beats are dropped here; the completed word waits for the output slot.
                if (accept) begin
                    load    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    deserializer_out_buf #(
        .width(out_bit_width)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_word),
        .read_data (read_data),
        .data_ready(data_ready),
        .data_out  (data_out),
        .accept    (accept)
    );

`ifdef DESERIALIZER_OVERFLOW_EN
    logic drop_beat;
    assign drop_beat = (state_q == PEND) && write_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop_beat) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - scoreboard bench for deserializer (in=32, out=512)
module tb_deserializer;

    localparam int IW = 32;
    localparam int OW = 512;
    localparam int N  = OW / IW;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_data;
    logic [IW-1:0] data_in;
    logic          data_ready;
    logic          read_data;
    logic [OW-1:0] data_out;
`ifdef DESERIALIZER_OVERFLOW_EN
    logic          overflow;
`endif

    int total = 0;
    int bad   = 0;
    logic [OW-1:0] exp_q[$];

    deserializer #(
        .in_bit_width (IW),
        .out_bit_width(OW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .write_data(write_data),
        .data_in   (data_in),
        .data_ready(data_ready),
        .read_data (read_data),
        .data_out  (data_out)
`ifdef DESERIALIZER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] mk_word(input int base);
        logic [OW-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) w[i*IW +: IW] = 32'(base + i);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int v);
        write_data = 1'b1;
        data_in    = 32'(v);
        step();
        write_data = 1'b0;
    endtask

    // Monitor: every accepted word is popped from the scoreboard and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && data_ready === 1'b1 && read_data === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h expected none", data_out);
                end else begin
                    check("word", data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        write_data = 1'b0;
        read_data  = 1'b0;
        data_in    = '0;
        #12;
        check("reset_ready", data_ready, 0);
        check("reset_data", data_out, '0);
`ifdef DESERIALIZER_OVERFLOW_EN
        check("reset_overflow", overflow, 0);
`endif
        step();
        reset = 1'b1;
        step();

        // Single word back-to-back, always-ready consumer
        read_data = 1'b1;
        exp_q.push_back(mk_word(0));
        for (int i = 0; i < 15; i++) beat(i);
        check("t030_not_ready_early", data_ready, 0);
        beat(15);
        check("t030_ready_latency", data_ready, 1);
        step();
        check("t030_drained", data_ready, 0);

        // 256 contiguous beats -> 16 words
        for (int k = 0; k < 16; k++) exp_q.push_back(mk_word(16 * k));
        for (int i = 0; i < 256; i++) beat(i);
        step();
        check("t031_all_words", exp_q.size(), 0);
`ifdef DESERIALIZER_OVERFLOW_EN
        check("t031_no_overflow", overflow, 0);
`endif

        // Beats every other cycle
        exp_q.push_back(mk_word(0));
        for (int i = 0; i < 16; i++) begin
            beat(i);
            if (i == 14) check("t033_not_ready_early", data_ready, 0);
            if (i != 15) step();
        end
        check("t033_ready_latency", data_ready, 1);
        step();
        check("t033_all_words", exp_q.size(), 0);

        // Stalled consumer: word 0 held, word 1 pending, beat 32 dropped
        read_data = 1'b0;
        for (int i = 0; i < 33; i++) beat(1000 + i);
        check("t032_ready", data_ready, 1);
        check("t032_word0_held", data_out, mk_word(1000));
        step();
        step();
        check("t032_word0_stable", data_out, mk_word(1000));
`ifdef DESERIALIZER_OVERFLOW_EN
        check("t032_overflow", overflow, 1);
`endif
        exp_q.push_back(mk_word(1000));
        exp_q.push_back(mk_word(1016));
        read_data = 1'b1;
        step();
        check("t032_word1_ready", data_ready, 1);
        check("t032_word1_next", data_out, mk_word(1016));
        step();
        check("t032_drained", data_ready, 0);
        exp_q.push_back(mk_word(2000));
        for (int i = 0; i < 16; i++) beat(2000 + i);
        step();
        check("t032_realigned", exp_q.size(), 0);

        // Reset mid-word
        for (int i = 0; i < 8; i++) beat(500 + i);
        reset = 1'b0;
        #1;
        check("t034_reset_ready", data_ready, 0);
        check("t034_reset_data", data_out, '0);
`ifdef DESERIALIZER_OVERFLOW_EN
        check("t034_reset_overflow", overflow, 0);
`endif
        step();
        reset = 1'b1;
        step();
        exp_q.push_back(mk_word(100));
        for (int i = 0; i < 16; i++) beat(100 + i);
        step();
        check("t034_after_reset", exp_q.size(), 0);

        // Consume on the same cycle as the next word's last beat
        read_data = 1'b0;
        exp_q.push_back(mk_word(3000));
        exp_q.push_back(mk_word(3016));
        for (int i = 0; i < 16; i++) beat(3000 + i);
        check("t035_word0_ready", data_ready, 1);
        for (int i = 0; i < 15; i++) beat(3016 + i);
        check("t035_still_word0", data_out, mk_word(3000));
        read_data = 1'b1;
        beat(3031);
        check("t035_ready_held", data_ready, 1);
        check("t035_word1_next", data_out, mk_word(3016));
        step();
        check("t035_drained", data_ready, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
